// File: rtl/bbox_pkg.sv
// Shared types and helpers for the multi-class bounding-box scanner.
package bbox_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam int PIX_W_DEF = 24;
  localparam int COMP_W    = PIX_W_DEF / 3;
  localparam int MAX_PIX_W = 96;

  // Component idx (0 = low/blue) of a pixel made of cw-bit components.
  function automatic logic [31:0] comp_of(input logic [MAX_PIX_W-1:0] pix,
                                          input int idx, input int cw);
    logic [MAX_PIX_W-1:0] mask;
    mask = ~({MAX_PIX_W{1'b1}} << cw);
    return 32'((pix >> (idx * cw)) & mask);
  endfunction

  function automatic logic in_range(input logic [31:0] c, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (lo <= c) && (c <= hi);
  endfunction

endpackage

// File: rtl/bbox_class_acc.sv
// One colour class: range compare plus min/max/count accumulators.
// Exposes next-state values so the final pixel can be captured directly.
module bbox_class_acc
  import bbox_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int PIX_W = 24,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H),
  parameter int CNT_W = $clog2(IMG_W*IMG_H) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             upd_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [PIX_W-1:0] lo_i,
  input  logic [PIX_W-1:0] hi_i,
  input  logic [XW-1:0]    x_i,
  input  logic [YW-1:0]    y_i,
  output logic [XW-1:0]    xmin_nx_o,
  output logic [XW-1:0]    xmax_nx_o,
  output logic [YW-1:0]    ymin_nx_o,
  output logic [YW-1:0]    ymax_nx_o,
  output logic [CNT_W-1:0] cnt_nx_o
);

  localparam int CW = PIX_W / 3;

  logic             hit;
  logic [XW-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    hit = 1'b1;
    for (int c = 0; c < 3; c++)
      hit = hit & in_range(comp_of(MAX_PIX_W'(pix_i), c, CW),
                           comp_of(MAX_PIX_W'(lo_i), c, CW),
                           comp_of(MAX_PIX_W'(hi_i), c, CW));
  end

  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (init_i) begin
      xmin_d = XW'(IMG_W - 1);
      ymin_d = YW'(IMG_H - 1);
      xmax_d = '0;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (upd_i && hit) begin
      if (x_i < xmin_q) xmin_d = x_i;
      if (x_i > xmax_q) xmax_d = x_i;
      if (y_i < ymin_q) ymin_d = y_i;
      if (y_i > ymax_q) ymax_d = y_i;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
    end
  end

  assign xmin_nx_o = xmin_d;
  assign xmax_nx_o = xmax_d;
  assign ymin_nx_o = ymin_d;
  assign ymax_nx_o = ymax_d;
  assign cnt_nx_o  = cnt_d;

endmodule

// File: rtl/bbox_scanner.sv
// Raster-scans a frame RAM and reports a tight bounding box and match count
// per colour class; results are registered and held until the next DONE.
module bbox_scanner
  import bbox_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int PIX_W       = 24,
  parameter int NUM_CLASSES = 2,
  parameter int ADDR_W      = $clog2(IMG_W*IMG_H)
) (
  input  logic                                    CLOCK_50,
  input  logic                                    reset,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic [ADDR_W-1:0]                       rd_addr,
  output logic                                    rd_en,
  input  logic [PIX_W-1:0]                        rd_data,
  input  logic [NUM_CLASSES*PIX_W-1:0]            class_lo,
  input  logic [NUM_CLASSES*PIX_W-1:0]            class_hi,
  output logic [NUM_CLASSES-1:0]                  box_valid,
  output logic [NUM_CLASSES*$clog2(IMG_W)-1:0]    box_xmin,
  output logic [NUM_CLASSES*$clog2(IMG_W)-1:0]    box_xmax,
  output logic [NUM_CLASSES*$clog2(IMG_H)-1:0]    box_ymin,
  output logic [NUM_CLASSES*$clog2(IMG_H)-1:0]    box_ymax,
  output logic [NUM_CLASSES*(ADDR_W+1)-1:0]       box_count
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int CNT_W = ADDR_W + 1;
  localparam int NPIX  = IMG_W * IMG_H;

  state_t state_q, state_d;
  logic   start_acc, last_addr;

  logic [ADDR_W-1:0]            addr_q;
  logic [XW-1:0]                x_q, px_q;
  logic [YW-1:0]                y_q, py_q;
  logic                         vld_q;
  logic [NUM_CLASSES*PIX_W-1:0] lo_q, hi_q;

  logic [NUM_CLASSES-1:0][XW-1:0]    xmin_nx, xmax_nx, xmin_q, xmax_q;
  logic [NUM_CLASSES-1:0][YW-1:0]    ymin_nx, ymax_nx, ymin_q, ymax_q;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_nx, cnt_q;
  logic [NUM_CLASSES-1:0]            valid_q;

  assign start_acc = (state_q == S_IDLE) && start;
  assign last_addr = (addr_q == ADDR_W'(NPIX - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (last_addr) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    rd_en = (state_q == S_SCAN);
  end

  // Address and (x,y) advance together so no multiplier is needed.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      vld_q  <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      vld_q <= rd_en;
      px_q  <= x_q;
      py_q  <= y_q;
      if (start_acc) begin
        addr_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
        lo_q   <= class_lo;
        hi_q   <= class_hi;
      end else if (state_q == S_SCAN) begin
        if (last_addr) begin
          addr_q <= '0;
          x_q    <= '0;
          y_q    <= '0;
        end else begin
          addr_q <= addr_q + 1'b1;
          if (x_q == XW'(IMG_W - 1)) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
    end
  end

  assign rd_addr = addr_q;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
    bbox_class_acc #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
      .XW(XW), .YW(YW), .CNT_W(CNT_W)
    ) u_acc (
      .clk       (CLOCK_50),
      .rst       (reset),
      .init_i    (start_acc),
      .upd_i     (vld_q),
      .pix_i     (rd_data),
      .lo_i      (lo_q[k*PIX_W +: PIX_W]),
      .hi_i      (hi_q[k*PIX_W +: PIX_W]),
      .x_i       (px_q),
      .y_i       (py_q),
      .xmin_nx_o (xmin_nx[k]),
      .xmax_nx_o (xmax_nx[k]),
      .ymin_nx_o (ymin_nx[k]),
      .ymax_nx_o (ymax_nx[k]),
      .cnt_nx_o  (cnt_nx[k])
    );

    assign box_xmin [k*XW +: XW]       = xmin_q[k];
    assign box_xmax [k*XW +: XW]       = xmax_q[k];
    assign box_ymin [k*YW +: YW]       = ymin_q[k];
    assign box_ymax [k*YW +: YW]       = ymax_q[k];
    assign box_count[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  // Loaded on the DRAIN edge from next-state values so the final pixel is
  // included and results are already visible while done is high.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_DRAIN) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        valid_q[k] <= (cnt_nx[k] != '0);
        cnt_q[k]   <= cnt_nx[k];
        xmin_q[k]  <= (cnt_nx[k] != '0) ? xmin_nx[k] : '0;
        xmax_q[k]  <= (cnt_nx[k] != '0) ? xmax_nx[k] : '0;
        ymin_q[k]  <= (cnt_nx[k] != '0) ? ymin_nx[k] : '0;
        ymax_q[k]  <= (cnt_nx[k] != '0) ? ymax_nx[k] : '0;
      end
    end
  end

  assign box_valid = valid_q;

endmodule
